// File: rtl/sdio_data_defines.sv
// Shared definitions for the SDIO data block sequencer.
//   state_t     : sequencer state encodings
//   status_t    : transfer completion codes reported on o_status
//   TOKEN_*     : CRC status token bit patterns (start bit, 3 status bits, end bit are
//                 framed by the PHY; only the 3 status bits live here)
//   DEFAULT_BYTE_COUNT : byte-mode length used when the requested count is 0
//   xfer_len()  : per-activation PHY data count for the current mode
package sdio_data_defines;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER,
        ST_CRC_CHK,
        ST_STATUS,
        ST_BUSY,
        ST_GAP,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_CRC_ERR = 2'd1,
        STATUS_ABORTED = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_t;

    localparam logic [2:0] TOKEN_GOOD    = 3'b010;
    localparam logic [2:0] TOKEN_CRC_ERR = 3'b101;

    localparam logic [9:0] DEFAULT_BYTE_COUNT = 10'd512;

    // Block mode sends block_size bytes per activation; byte mode sends the
    // requested byte count, where 0 encodes a full 512-byte transfer.
    function automatic logic [9:0] xfer_len(input logic       block_mode,
                                            input logic [9:0] block_size,
                                            input logic [9:0] byte_count);
        if (block_mode)
            return block_size;
        else if (byte_count == 10'd0)
            return DEFAULT_BYTE_COUNT;
        else
            return byte_count;
    endfunction

endpackage

// File: rtl/sdio_phase_timer.sv
// Loadable down-counter paced by the SDIO clock phase strobe.
//   clk_x2     : clock, 2x the SDIO clock
//   rst        : synchronous, active-high reset
//   phase      : one-cycle strobe per SDIO clock rising edge; decrements the count
//   load       : load load_value (takes priority over decrementing)
//   load_value : interval length minus one
//   zero       : count has reached zero
module sdio_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk_x2,
    input  logic         rst,
    input  logic         phase,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_x2) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (phase && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdio_data_block_ctrl.sv
// SDIO data block sequencer: runs one CMD53 transfer as a series of single-block
// PHY activations, adding CRC status token and DAT0 busy handling for writes.
//
// Optional build macro SDIO_DATA_TIMEOUT_EN: enables a TIMEOUT_CYCLES-phase
// watchdog on the PHY transfer; without it status TIMEOUT is never produced.
//
// Ports:
//   clk_x2, rst            : clock (2x SDIO clk), synchronous active-high reset
//   i_clk_phase            : strobe per SDIO clk rising edge; paces all PHY-side outputs
//   i_start .. i_byte_count: transfer request and configuration (sampled in IDLE)
//   i_abort                : level, terminates the transfer on the next phase
//   i_fifo_ready           : data buffer can take / supply the next block
//   o_busy, o_done, o_status, o_blocks_done : function-layer status
//   o_phy_activate, o_phy_write_flag, o_phy_data_count, i_phy_finished,
//   i_phy_crc_good         : data PHY control / completion
//   o_token_valid, o_token : CRC status token request
//   o_dat0_busy            : hold DAT0 low while the card is busy after a write
module sdio_data_block_ctrl
    import sdio_data_defines::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int BUSY_CYCLES    = 8,
    parameter int TOKEN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_x2,
    input  logic       rst,
    input  logic       i_clk_phase,
    input  logic       i_start,
    input  logic       i_write,
    input  logic       i_block_mode,
    input  logic [9:0] i_block_size,
    input  logic [8:0] i_block_count,
    input  logic [9:0] i_byte_count,
    input  logic       i_abort,
    input  logic       i_fifo_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_status,
    output logic [8:0] o_blocks_done,
    output logic       o_phy_activate,
    output logic       o_phy_write_flag,
    output logic [9:0] o_phy_data_count,
    input  logic       i_phy_finished,
    input  logic       i_phy_crc_good,
    output logic       o_token_valid,
    output logic [2:0] o_token,
    output logic       o_dat0_busy
);

    localparam int MAX_GB  = (GAP_CYCLES > BUSY_CYCLES) ? GAP_CYCLES : BUSY_CYCLES;
    localparam int MAX_GBT = (MAX_GB > TOKEN_CYCLES) ? MAX_GB : TOKEN_CYCLES;
    localparam int MAX_CYC = (MAX_GBT > TIMEOUT_CYCLES) ? MAX_GBT : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    // The timer is loaded with length-1: the load lands on the cycle after the
    // phase that started the interval, and the interval ends on the phase at
    // which the count is already zero, giving exactly N phases.
    localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] BUSY_LOAD    = TMR_W'(BUSY_CYCLES - 1);
    localparam logic [TMR_W-1:0] TOKEN_LOAD   = TMR_W'(TOKEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             cfg_write;
    logic [8:0]       cfg_count;
    logic [9:0]       cfg_len;
    logic             crc_ok;
    logic             gap_armed;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    sdio_phase_timer #(.W(TMR_W)) u_timer (
        .clk_x2     (clk_x2),
        .rst        (rst),
        .phase      (i_clk_phase),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk_x2) begin
        if (rst) begin
            state            <= ST_IDLE;
            cfg_write        <= 1'b0;
            cfg_count        <= '0;
            cfg_len          <= '0;
            crc_ok           <= 1'b0;
            gap_armed        <= 1'b0;
            tmr_load         <= 1'b0;
            tmr_value        <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_status         <= '0;
            o_blocks_done    <= '0;
            o_phy_activate   <= 1'b0;
            o_phy_write_flag <= 1'b0;
            o_phy_data_count <= '0;
            o_token_valid    <= 1'b0;
            o_token          <= '0;
            o_dat0_busy      <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            tmr_load <= 1'b0;
            // While abort is pending all other events are frozen, so it wins
            // over a coincident PHY completion; it takes effect on the next phase.
            if (i_abort && state != ST_IDLE && state != ST_FINISH) begin
                if (i_clk_phase) begin
                    o_phy_activate <= 1'b0;
                    o_token_valid  <= 1'b0;
                    o_token        <= '0;
                    o_dat0_busy    <= 1'b0;
                    gap_armed      <= 1'b0;
                    o_status       <= STATUS_ABORTED;
                    state          <= ST_FINISH;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        // o_busy is still high on the cycle after o_done, so a
                        // start arriving then is ignored.
                        o_busy <= 1'b0;
                        if (i_start && !o_busy) begin
                            cfg_write     <= i_write;
                            cfg_count     <= i_block_mode ? i_block_count : 9'd1;
                            cfg_len       <= xfer_len(i_block_mode, i_block_size, i_byte_count);
                            o_blocks_done <= '0;
                            o_status      <= STATUS_OK;
                            o_busy        <= 1'b1;
                            state         <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (i_clk_phase && i_fifo_ready) begin
                            o_phy_activate   <= 1'b1;
                            o_phy_write_flag <= cfg_write;
                            o_phy_data_count <= cfg_len;
                            tmr_load         <= 1'b1;
                            tmr_value        <= TIMEOUT_LOAD;
                            state            <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (i_phy_finished) begin
                            if (cfg_write) begin
                                state <= ST_CRC_CHK;
                            end else begin
                                o_blocks_done <= sat_inc(o_blocks_done);
                                state         <= ST_GAP;
                            end
                        end
`ifdef SDIO_DATA_TIMEOUT_EN
                        else if (i_clk_phase && tmr_zero) begin
                            o_phy_activate <= 1'b0;
                            o_status       <= STATUS_TIMEOUT;
                            state          <= ST_FINISH;
                        end
`else
                        // No watchdog: wait for the PHY or an abort.
`endif
                    end
                    ST_CRC_CHK: begin
                        crc_ok <= i_phy_crc_good;
                        state  <= ST_STATUS;
                    end
                    ST_STATUS: begin
                        if (i_clk_phase) begin
                            if (!o_token_valid) begin
                                o_token_valid <= 1'b1;
                                o_token       <= crc_ok ? TOKEN_GOOD : TOKEN_CRC_ERR;
                                tmr_load      <= 1'b1;
                                tmr_value     <= TOKEN_LOAD;
                            end else if (tmr_zero) begin
                                o_token_valid  <= 1'b0;
                                o_phy_activate <= 1'b0;
                                if (crc_ok) begin
                                    o_dat0_busy <= 1'b1;
                                    tmr_load    <= 1'b1;
                                    tmr_value   <= BUSY_LOAD;
                                    state       <= ST_BUSY;
                                end else begin
                                    o_status <= STATUS_CRC_ERR;
                                    state    <= ST_FINISH;
                                end
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (i_clk_phase && tmr_zero && i_fifo_ready) begin
                            o_dat0_busy   <= 1'b0;
                            o_blocks_done <= sat_inc(o_blocks_done);
                            state         <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // First phase drops activate and starts the gap interval.
                        if (i_clk_phase) begin
                            if (!gap_armed) begin
                                o_phy_activate <= 1'b0;
                                gap_armed      <= 1'b1;
                                tmr_load       <= 1'b1;
                                tmr_value      <= GAP_LOAD;
                            end else if (tmr_zero) begin
                                gap_armed <= 1'b0;
                                if (cfg_count != '0 && o_blocks_done == cfg_count)
                                    state <= ST_FINISH;
                                else
                                    state <= ST_ARM;
                            end
                        end
                    end
                    ST_FINISH: begin
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdio_data_block_ctrl.sv
// Scoreboard bench for sdio_data_block_ctrl: stimulus pushes expected activations,
// tokens, busy lengths and completions; a negedge monitor pops and compares.
module tb_sdio_data_block_ctrl;

    localparam int GAP_C   = 2;
    localparam int BUSY_C  = 8;
    localparam int TOKEN_C = 5;
    localparam int TOUT_C  = 16;
    localparam int PHY_LAT = 6;

    logic       clk_x2 = 1'b0;
    logic       rst;
    logic       i_clk_phase;
    logic       i_start, i_write, i_block_mode;
    logic [9:0] i_block_size;
    logic [8:0] i_block_count;
    logic [9:0] i_byte_count;
    logic       abort;
    logic       i_fifo_ready;
    logic       o_busy, o_done;
    logic [1:0] o_status;
    logic [8:0] o_blocks_done;
    logic       o_phy_activate, o_phy_write_flag;
    logic [9:0] o_phy_data_count;
    logic       fin, crc_good;
    logic       o_token_valid;
    logic [2:0] o_token;
    logic       o_dat0_busy;

    sdio_data_block_ctrl #(
        .GAP_CYCLES(GAP_C), .BUSY_CYCLES(BUSY_C),
        .TOKEN_CYCLES(TOKEN_C), .TIMEOUT_CYCLES(TOUT_C)
    ) dut (
        .clk_x2(clk_x2), .rst(rst), .i_clk_phase(i_clk_phase),
        .i_start(i_start), .i_write(i_write), .i_block_mode(i_block_mode),
        .i_block_size(i_block_size), .i_block_count(i_block_count),
        .i_byte_count(i_byte_count), .i_abort(abort), .i_fifo_ready(i_fifo_ready),
        .o_busy(o_busy), .o_done(o_done), .o_status(o_status),
        .o_blocks_done(o_blocks_done), .o_phy_activate(o_phy_activate),
        .o_phy_write_flag(o_phy_write_flag), .o_phy_data_count(o_phy_data_count),
        .i_phy_finished(fin), .i_phy_crc_good(crc_good),
        .o_token_valid(o_token_valid), .o_token(o_token), .o_dat0_busy(o_dat0_busy)
    );

    always #5 clk_x2 = ~clk_x2;

    initial begin
        i_clk_phase = 1'b0;
        forever begin
            @(posedge clk_x2);
            #1 i_clk_phase = ~i_clk_phase;
        end
    end

    typedef struct { logic [1:0] status; logic [8:0] blocks; } done_exp_t;
    typedef struct { logic [9:0] len; logic wr; } act_exp_t;

    done_exp_t  sb_done[$];
    act_exp_t   sb_act[$];
    logic [2:0] sb_tok[$];
    int         sb_busy[$];   // >0: exact length in cycles, <0: minimum length

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_count = 0;
    int   blk_idx  = 0;
    int   abort_blk = -1;
    logic phy_en   = 1'b1;
    logic crc_plan [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Monitor: compare DUT events against the scoreboard queues.
    initial begin
        logic prev_act, prev_tok, prev_busy;
        int tok_len, busy_len, e_busy;
        done_exp_t d;
        act_exp_t a;
        prev_act = 0; prev_tok = 0; prev_busy = 0; tok_len = 0; busy_len = 0;
        forever begin
            @(negedge clk_x2);
            if (o_done) begin
                done_count++;
                if (sb_done.size() == 0) check("done_unexpected", 32'(o_done), 32'd0);
                else begin
                    d = sb_done.pop_front();
                    check("done_status", 32'(o_status), 32'(d.status));
                    check("blocks_done", 32'(o_blocks_done), 32'(d.blocks));
                end
            end
            if (o_phy_activate && !prev_act) begin
                if (sb_act.size() == 0) check("act_unexpected", 32'(o_phy_activate), 32'd0);
                else begin
                    a = sb_act.pop_front();
                    check("data_count", 32'(o_phy_data_count), 32'(a.len));
                    check("write_flag", 32'(o_phy_write_flag), 32'(a.wr));
                end
            end
            if (o_token_valid) begin
                if (!prev_tok) begin
                    tok_len = 0;
                    if (sb_tok.size() == 0) check("token_unexpected", 32'(o_token_valid), 32'd0);
                    else check("token_value", 32'(o_token), 32'(sb_tok.pop_front()));
                end
                tok_len++;
            end else if (prev_tok) begin
                check("token_len", 32'(tok_len), 32'(2 * TOKEN_C));
            end
            if (o_dat0_busy) begin
                if (!prev_busy) busy_len = 0;
                busy_len++;
            end else if (prev_busy) begin
                if (sb_busy.size() == 0) check("busy_unexpected", 32'(prev_busy), 32'd0);
                else begin
                    e_busy = sb_busy.pop_front();
                    if (e_busy > 0) check("busy_len", 32'(busy_len), 32'(e_busy));
                    else check("busy_len_min", 32'(busy_len >= -e_busy), 32'd1);
                end
            end
            prev_act = o_phy_activate; prev_tok = o_token_valid; prev_busy = o_dat0_busy;
        end
    end

    // PHY model: completes each activation after PHY_LAT cycles.
    initial begin
        logic seen;
        seen = 0; fin = 0; crc_good = 1; abort = 0;
        forever begin
            @(negedge clk_x2);
            if (!o_phy_activate || rst) seen = 0;
            else if (!seen && phy_en) begin
                seen = 1;
                repeat (PHY_LAT) @(posedge clk_x2);
                #1;
                crc_good = crc_plan[blk_idx];
                fin = 1;
                if (blk_idx == abort_blk) abort = 1;
                @(posedge clk_x2);
                #1 fin = 0;
                blk_idx++;
                if (abort) begin
                    while (o_busy) @(negedge clk_x2);
                    #1 abort = 0;
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk_x2);
        $display("FAIL watchdog: actual %0d required %0d", done_count, -1);
        $fatal(1, "bench watchdog expired");
    end

    task automatic start_xfer(input logic wr, input logic bm, input logic [9:0] bsize,
                              input logic [8:0] bcount, input logic [9:0] bytes);
        @(posedge clk_x2); #1;
        i_write = wr; i_block_mode = bm; i_block_size = bsize;
        i_block_count = bcount; i_byte_count = bytes; i_start = 1'b1;
        @(posedge clk_x2); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin @(negedge clk_x2); n++; end
        check("done_wait", 32'(done_count), 32'(target));
    endtask

    task automatic wait_act(input logic level, input int budget, input string name);
        int n = 0;
        while (o_phy_activate !== level && n < budget) begin @(negedge clk_x2); n++; end
        check(name, 32'(o_phy_activate), 32'(level));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_status"}, 32'(o_status), 32'd0);
        check({tag, "_blocks"}, 32'(o_blocks_done), 32'd0);
        check({tag, "_phy"}, 32'({o_phy_activate, o_phy_write_flag, o_phy_data_count}), 32'd0);
        check({tag, "_token"}, 32'({o_token_valid, o_token, o_dat0_busy}), 32'd0);
    endtask

    initial begin
        int n, exp_done, base, d0;
        for (int i = 0; i < 64; i++) crc_plan[i] = 1'b1;
        rst = 1; i_start = 0; i_write = 0; i_block_mode = 0; i_block_size = 0;
        i_block_count = 0; i_byte_count = 0; i_fifo_ready = 1;
        exp_done = 0;
        repeat (4) @(posedge clk_x2);
        #1 rst = 0;
        @(negedge clk_x2);
        check_idle_outputs("reset");

        // Byte-mode read, count 0 -> 512 bytes, one block.
        sb_act.push_back('{10'd512, 1'b0});
        sb_done.push_back('{2'd0, 9'd1});
        start_xfer(1'b0, 1'b0, 10'd0, 9'd0, 10'd0);
        check("busy_after_start", 32'(o_busy), 32'd1);
        wait_act(1'b1, 50, "t1_act_rise");
        wait_act(1'b0, 50, "t1_act_fall");
        n = 0;
        while (!o_done && n < 50) begin @(negedge clk_x2); n++; end
        check("t1_gap_len_ok", 32'(n >= 2 * GAP_C), 32'd1);
        exp_done++; wait_done(exp_done, 100);

        // Block write, size 64, count 3, CRC good.
        for (int i = 0; i < 3; i++) begin
            sb_act.push_back('{10'd64, 1'b1});
            sb_tok.push_back(3'b010);
            sb_busy.push_back(2 * BUSY_C);
        end
        sb_done.push_back('{2'd0, 9'd3});
        start_xfer(1'b1, 1'b1, 10'd64, 9'd3, 10'd0);
        exp_done++; wait_done(exp_done, 1000);

        // Block write, count 3, CRC bad on block 2.
        base = blk_idx;
        crc_plan[base + 1] = 1'b0;
        sb_act.push_back('{10'd64, 1'b1});
        sb_act.push_back('{10'd64, 1'b1});
        sb_tok.push_back(3'b010);
        sb_tok.push_back(3'b101);
        sb_busy.push_back(2 * BUSY_C);
        sb_done.push_back('{2'd1, 9'd1});
        start_xfer(1'b1, 1'b1, 10'd64, 9'd3, 10'd0);
        exp_done++; wait_done(exp_done, 1000);

        // Infinite read, abort coincident with completion of block 6.
        base = blk_idx;
        abort_blk = base + 5;
        for (int i = 0; i < 6; i++) sb_act.push_back('{10'd32, 1'b0});
        sb_done.push_back('{2'd2, 9'd5});
        start_xfer(1'b0, 1'b1, 10'd32, 9'd0, 10'd0);
        exp_done++; wait_done(exp_done, 2000);
        n = 0;
        while (abort && n < 50) begin @(negedge clk_x2); n++; end
        check("abort_released", 32'(abort), 32'd0);
        abort_blk = -1;

        // Write with fifo not ready for 20 phases during BUSY; start while busy ignored.
        sb_act.push_back('{10'd16, 1'b1});
        sb_tok.push_back(3'b010);
        sb_busy.push_back(-40);
        sb_done.push_back('{2'd0, 9'd1});
        start_xfer(1'b1, 1'b1, 10'd16, 9'd1, 10'd0);
        n = 0;
        while (!o_dat0_busy && n < 200) begin @(negedge clk_x2); n++; end
        check("t5_busy_seen", 32'(o_dat0_busy), 32'd1);
        @(posedge clk_x2); #1;
        i_fifo_ready = 1'b0;
        i_start = 1'b1; i_write = 1'b0; i_block_mode = 1'b0;
        @(posedge clk_x2); #1 i_start = 1'b0;
        repeat (39) @(posedge clk_x2);
        #1 i_fifo_ready = 1'b1;
        exp_done++; wait_done(exp_done, 500);

`ifdef SDIO_DATA_TIMEOUT_EN
        // PHY never finishes: watchdog ends the transfer with TIMEOUT.
        phy_en = 1'b0;
        sb_act.push_back('{10'd8, 1'b0});
        sb_done.push_back('{2'd3, 9'd0});
        start_xfer(1'b0, 1'b0, 10'd0, 9'd0, 10'd8);
        wait_act(1'b1, 50, "t6_act_rise");
        n = 0;
        while (!o_done && n < 200) begin @(negedge clk_x2); n++; end
        check("timeout_latency", 32'(n), 32'(2 * TOUT_C + 1));
        exp_done++; wait_done(exp_done, 100);
        phy_en = 1'b1;
`endif

        // Reset in the middle of XFER: outputs clear, no completion pulse.
        phy_en = 1'b0;
        sb_act.push_back('{10'd8, 1'b0});
        start_xfer(1'b0, 1'b0, 10'd0, 9'd0, 10'd8);
        wait_act(1'b1, 50, "t7_act_rise");
        repeat (6) @(posedge clk_x2);
        #1 rst = 1'b1;
        @(posedge clk_x2); #1 rst = 1'b0;
        @(negedge clk_x2);
        check_idle_outputs("midrst");
        d0 = done_count;
        repeat (30) @(negedge clk_x2);
        check("midrst_no_done", 32'(done_count), 32'(d0));
        phy_en = 1'b1;

        check("sb_done_left", 32'(sb_done.size()), 32'd0);
        check("sb_act_left", 32'(sb_act.size()), 32'd0);
        check("sb_tok_left", 32'(sb_tok.size()), 32'd0);
        check("sb_busy_left", 32'(sb_busy.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
